soc: RTL and testbench
======================

# soc

Minimal RISC-V RV32I instruction-decoder SoC. It steps through a fixed 32-word instruction ROM and classifies each opcode. It shows the class on five LEDs and reports each decoded instruction as one ASCII character over a UART transmitter. It is the top-level block that sits between the board pins (clock, reset, UART, LEDs) and the future CPU datapath. It is the bring-up stage that validates instruction decoding before execution is added.

## Interface
- CLKS_PER_BIT, default 16: clock cycles per UART bit (8N1).
- CLK  input  1  system clock; all state updates on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- TXD  output  1  UART transmit line, idles high.
- RXD  input  1  UART receive line; unused in this block, ignored.
- LEDS  output  5  decode status display.

## Operation
- ROM: 32 words × 32 bit, word-indexed by a 5-bit `pc`. Default contents:
  - 0: 0x00000033 (add x0,x0,x0)
  - 1: 0x000000B3 (add x1,x0,x0)
  - 2: 0x00108113 (addi x2,x1,1)
  - 3: 0x0000A183 (lw x3,0(x1))
  - 4: 0x0030A023 (sw x3,0(x1))
  - 5–31: 0x00100073 (ebreak)
- Decode on instr[6:0]:
  - 0110011 ALUreg 'R'
  - 0010011 ALUimm 'I'
  - 1100011 branch 'B'
  - 1101111 JAL 'J'
  - 1100111 JALR 'j'
  - 0110111 LUI 'U'
  - 0010111 AUIPC 'A'
  - 0000011 load 'L'
  - 0100011 store 'S'
  - 1110011 SYSTEM 'Y'
  - Any other opcode: '?'
- LEDS:
  - SYSTEM: 5'b11111.
  - Otherwise: {pc[0], isALUreg, isALUimm, isStore, isLoad}, computed from the registered instruction and the pc it was fetched from.
- FSM states: FETCH, SEND, WAIT, NEXT, HALT.
  - FETCH: instr <= rom[pc]; go to SEND.
  - SEND: pulse UART start with the class character; go to WAIT.
  - WAIT: hold until the UART reports done. If instr is SYSTEM, go to HALT; else go to NEXT.
  - NEXT: pc <= pc + 1, wrapping 31 -> 0; go to FETCH.
  - HALT: terminal. pc, instr, LEDS and TXD (=1) stay frozen until reset.
- UART TX frame: start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts CLKS_PER_BIT cycles. Start requests are only issued when the UART is idle.
- Reset values: pc=0, instr=0, state=FETCH, TXD=1, LEDS=5'b00000, UART idle.
- Reset asserted mid-frame: TXD goes to 1 immediately, the frame is aborted, and the sequence restarts from pc=0 after release.

## Timing
- Edge 1 after reset release: instr loaded and LEDS valid.
- Edge 2: TXD falls (start bit).
- The frame occupies 10·CLKS_PER_BIT cycles. Done is asserted on the cycle the stop bit completes.
- The next instruction loads 3 cycles after done (WAIT→NEXT→FETCH→load).
- Instruction period is 10·CLKS_PER_BIT + 3 cycles. The default program halts after 6 characters.
- LEDS change only on instr/pc update, never mid-frame.
- RXD has no effect on any output.

## Test plan
- Reset held, then released:
  - While held: TXD=1 and LEDS=00000.
  - One edge after release: LEDS=01000 (pc0, ALUreg).
- Default program run: LEDS sequence is 01000, 11000, 00100, 10001, 00010, 11111, then no further change.
- UART capture at CLKS_PER_BIT=16: bytes received are "R","R","I","L","S","Y" (0x52,0x52,0x49,0x4C,0x53,0x59), each with a 0 start bit and a 1 stop bit. Nothing is sent after 'Y'.
- Frame timing: the falling edge of each start bit is exactly 163 cycles after the previous one (CLKS_PER_BIT=16).
- Reset mid-frame during the third character:
  - TXD returns to 1 and LEDS=00000 immediately.
  - After release the sequence restarts with 'R' and LEDS=01000.
- ROM override with no SYSTEM word and an unknown opcode (e.g. 0x0000007F): '?' is sent, LEDS={pc[0],0000}, and pc wraps 31→0.
- RXD toggled randomly throughout: TXD and LEDS are identical to a run with RXD held high.

Source files
------------

// File: rtl/soc_if.sv
// Board-side pins of the decoder SoC: UART lines and the status LEDs.
// The SoC uses the slave view; the board or testbench uses the master view.
interface soc_if;
  logic       TXD;
  logic       RXD;
  logic [4:0] LEDS;

  modport slave (
    output TXD,
    output LEDS,
    input  RXD
  );

  modport master (
    input  TXD,
    input  LEDS,
    output RXD
  );
endinterface

// File: rtl/soc.sv
// RV32I bring-up SoC: walks a 32-word ROM, classifies each opcode, shows the
// class on five LEDs and sends one ASCII character per instruction over UART.
module soc #(
  parameter int          CLKS_PER_BIT = 16,
  parameter logic [1023:0] ROM_INIT   = {{27{32'h00100073}},
                                         32'h0030A023, 32'h0000A183,
                                         32'h00108113, 32'h000000B3,
                                         32'h00000033}
) (
  input  logic CLK,
  input  logic RESET,
  soc_if.slave pins
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  localparam logic [6:0] OP_ALUREG = 7'b0110011;
  localparam logic [6:0] OP_ALUIMM = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    S_FETCH,
    S_SEND,
    S_WAIT,
    S_NEXT,
    S_HALT
  } state_t;

  function automatic logic [7:0] class_char(input logic [6:0] op);
    case (op)
      OP_ALUREG: return "R";
      OP_ALUIMM: return "I";
      OP_BRANCH: return "B";
      OP_JAL:    return "J";
      OP_JALR:   return "j";
      OP_LUI:    return "U";
      OP_AUIPC:  return "A";
      OP_LOAD:   return "L";
      OP_STORE:  return "S";
      OP_SYSTEM: return "Y";
      default:   return "?";
    endcase
  endfunction

  function automatic logic [4:0] class_leds(input logic [6:0] op, input logic pc_lsb);
    if (op == OP_SYSTEM) begin
      return 5'b11111;
    end
    return {pc_lsb, op == OP_ALUREG, op == OP_ALUIMM, op == OP_STORE, op == OP_LOAD};
  endfunction

  logic [31:0] rom [32];

  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_rom
      assign rom[gi] = ROM_INIT[32*gi +: 32];
    end
  endgenerate

  state_t        state_q, state_d;
  logic [4:0]    pc_q, pc_d;
  logic [31:0]   instr_q, instr_d;
  logic [4:0]    leds_q, leds_d;

  logic          busy_q, busy_d;
  logic          tx_q, tx_d;
  logic [9:0]    frame_q, frame_d;
  logic [3:0]    bit_q, bit_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          tx_start;
  logic          tx_done;
  logic          is_system;

  // Only the opcode field is decoded at this stage; RXD is not yet wired up.
  logic [24:0]   instr_hi_unused;
  logic          rxd_unused;
  assign instr_hi_unused = instr_q[31:7];
  assign rxd_unused      = pins.RXD;

  assign is_system = (instr_q[6:0] == OP_SYSTEM);
  assign tx_start  = (state_q == S_SEND) && !busy_q;
  // Done is visible during the last stop-bit cycle so WAIT leaves on the edge the frame ends.
  assign tx_done   = busy_q && (cnt_q == CNT_MAX) && (bit_q == 4'd9);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    leds_d  = leds_q;
    case (state_q)
      S_FETCH: begin
        instr_d = rom[pc_q];
        leds_d  = class_leds(rom[pc_q][6:0], pc_q[0]);
        state_d = S_SEND;
      end
      S_SEND: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (tx_done) begin
          state_d = is_system ? S_HALT : S_NEXT;
        end
      end
      S_NEXT: begin
        pc_d    = pc_q + 5'd1;
        state_d = S_FETCH;
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  always_comb begin
    busy_d  = busy_q;
    tx_d    = tx_q;
    frame_d = frame_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    if (tx_start) begin
      frame_d = {1'b1, class_char(instr_q[6:0]), 1'b0};
      tx_d    = 1'b0;
      busy_d  = 1'b1;
      bit_d   = 4'd0;
      cnt_d   = '0;
    end else if (busy_q) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d = '0;
        if (bit_q == 4'd9) begin
          busy_d = 1'b0;
          tx_d   = 1'b1;
        end else begin
          // frame_q[0] always mirrors the bit currently on the line.
          frame_d = {1'b1, frame_q[9:1]};
          tx_d    = frame_q[1];
          bit_d   = bit_q + 4'd1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_FETCH;
      pc_q    <= 5'd0;
      instr_q <= 32'd0;
      leds_q  <= 5'd0;
      busy_q  <= 1'b0;
      tx_q    <= 1'b1;
      frame_q <= '1;
      bit_q   <= 4'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      leds_q  <= leds_d;
      busy_q  <= busy_d;
      tx_q    <= tx_d;
      frame_q <= frame_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pins.TXD  = tx_q;
  assign pins.LEDS = leds_q;

endmodule

// File: tb/tb_soc.sv
// Bench for the decoder SoC: decodes the UART stream and LEDs of three
// instances against a reference model of the ROM walk and character table.
module tb_soc;

  logic clk;
  logic rst;
  logic rst_c;
  int   cyc;
  int   n_tests;
  int   n_fail;
  int   rxd_diff;

  soc_if if_a ();
  soc_if if_b ();
  soc_if if_c ();

  function automatic logic [1023:0] mk_def();
    logic [1023:0] r;
    for (int i = 0; i < 32; i++) begin
      case (i)
        0:       r[32*i +: 32] = 32'h00000033;
        1:       r[32*i +: 32] = 32'h000000B3;
        2:       r[32*i +: 32] = 32'h00108113;
        3:       r[32*i +: 32] = 32'h0000A183;
        4:       r[32*i +: 32] = 32'h0030A023;
        default: r[32*i +: 32] = 32'h00100073;
      endcase
    end
    return r;
  endfunction

  // No SYSTEM word anywhere, so the walk never halts and pc must wrap.
  function automatic logic [1023:0] mk_ovr();
    logic [1023:0] r;
    logic [6:0]    op;
    for (int i = 0; i < 32; i++) begin
      case (i % 11)
        0:       op = 7'h7F;
        1:       op = 7'h33;
        2:       op = 7'h13;
        3:       op = 7'h63;
        4:       op = 7'h6F;
        5:       op = 7'h67;
        6:       op = 7'h37;
        7:       op = 7'h17;
        8:       op = 7'h03;
        9:       op = 7'h23;
        default: op = 7'h00;
      endcase
      r[32*i +: 32] = {5'(i), 20'hA5A5A, op};
    end
    return r;
  endfunction

  localparam logic [1023:0] ROM_DEF = mk_def();
  localparam logic [1023:0] ROM_OVR = mk_ovr();

  soc #(.CLKS_PER_BIT(16)) dut_a (.CLK(clk), .RESET(rst),   .pins(if_a.slave));
  soc #(.CLKS_PER_BIT(16)) dut_b (.CLK(clk), .RESET(rst),   .pins(if_b.slave));
  soc #(.CLKS_PER_BIT(4), .ROM_INIT(ROM_OVR))
                           dut_c (.CLK(clk), .RESET(rst_c), .pins(if_c.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic byte model_char(input logic [31:0] w);
    string         names;
    logic [6:0]    opc [10];
    names = "RIBJjUALSY";
    opc   = '{7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111, 7'b1100111,
              7'b0110111, 7'b0010111, 7'b0000011, 7'b0100011, 7'b1110011};
    for (int k = 0; k < 10; k++) begin
      if (w[6:0] == opc[k]) return names[k];
    end
    return "?";
  endfunction

  function automatic logic [4:0] model_leds(input byte c, input logic pc_lsb);
    if (c == "Y") return 5'b11111;
    return {pc_lsb, c == "R", c == "I", c == "S", c == "L"};
  endfunction

  function automatic logic get_txd(input int sel);
    return (sel == 0) ? if_a.TXD : if_c.TXD;
  endfunction

  function automatic logic [4:0] get_leds(input int sel);
    return (sel == 0) ? if_a.LEDS : if_c.LEDS;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input int sel, input int limit, input string tag, output int at_cyc);
    int n;
    n = 0;
    while (get_txd(sel) !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_start_seen"}, 32'(get_txd(sel)), 32'd0);
    at_cyc = cyc;
  endtask

  // Entered at the first negedge after the start-bit edge.
  task automatic rx_frame(input int sel, input int cpb, input string tag,
                          input byte exp_c, input logic [4:0] exp_l);
    logic [9:0] bits;
    logic [4:0] lv;
    lv = exp_l;
    repeat (cpb / 2) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) repeat (cpb) @(negedge clk);
      bits[k] = get_txd(sel);
      if (get_leds(sel) !== exp_l) lv = get_leds(sel);
    end
    check({tag, "_startbit"}, 32'(bits[0]), 32'd0);
    check({tag, "_data"},     32'(bits[8:1]), 32'(exp_c));
    check({tag, "_stopbit"},  32'(bits[9]), 32'd1);
    check({tag, "_leds"},     32'(lv), 32'(exp_l));
    $display("[TB] %s char=%c byte=%02h leds=%b", tag, bits[8:1], bits[8:1], lv);
  endtask

  // Entered at the negedge where reset has just been released.
  task automatic run_program(input int sel, input int cpb, input logic [1023:0] rom,
                             input int max_frames, input string tag);
    byte        chars [$];
    logic [4:0] leds [$];
    int         pc;
    int         prev;
    int         now;
    int         changes;
    bit         halted;
    logic [31:0] w;
    byte        c;
    pc     = 0;
    halted = 1'b0;
    for (int i = 0; i < 64 && chars.size() < max_frames; i++) begin
      w = rom[32*pc +: 32];
      c = model_char(w);
      chars.push_back(c);
      leds.push_back(model_leds(c, pc[0]));
      if (c == "Y") begin
        halted = 1'b1;
        break;
      end
      pc = (pc + 1) % 32;
    end
    @(negedge clk);
    check({tag, "_edge1_leds"}, 32'(get_leds(sel)), 32'(leds[0]));
    check({tag, "_edge1_txd"},  32'(get_txd(sel)), 32'd1);
    @(negedge clk);
    check({tag, "_edge2_txd"},  32'(get_txd(sel)), 32'd0);
    prev = cyc;
    for (int i = 0; i < chars.size(); i++) begin
      if (i > 0) begin
        wait_start(sel, 20 * cpb, $sformatf("%s_f%0d", tag, i), now);
        check($sformatf("%s_f%0d_gap", tag, i), 32'(now - prev), 32'(10 * cpb + 3));
        prev = now;
      end
      rx_frame(sel, cpb, $sformatf("%s_f%0d", tag, i), chars[i], leds[i]);
    end
    if (halted) begin
      changes = 0;
      repeat (40 * cpb) begin
        @(negedge clk);
        if (get_txd(sel) !== 1'b1 || get_leds(sel) !== 5'b11111) changes++;
      end
      check({tag, "_halt_quiet"}, 32'(changes), 32'd0);
    end
  endtask

  initial begin
    if_a.RXD = 1'b1;
    forever begin
      @(negedge clk);
      #3;
      if_a.RXD = 1'($urandom());
    end
  end

  initial begin
    rxd_diff = 0;
    forever begin
      @(negedge clk);
      if (if_a.TXD !== if_b.TXD || if_a.LEDS !== if_b.LEDS) rxd_diff++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int off;
    int zero_bits [6];
    zero_bits = '{0, 2, 3, 5, 6, 8};
    n_tests   = 0;
    n_fail    = 0;
    cyc       = 0;
    if_b.RXD  = 1'b1;
    if_c.RXD  = 1'b1;
    rst       = 1'b1;
    rst_c     = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_txd",  32'(if_a.TXD), 32'd1);
    check("rst_leds", 32'(if_a.LEDS), 32'd0);

    rst = 1'b0;
    run_program(0, 16, ROM_DEF, 99, "def");

    // Reset again, then abort the third frame ('I') while a 0 bit is on the line.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    off = zero_bits[$urandom_range(0, 5)] * 16 + int'($urandom_range(1, 14));
    repeat (1 + 2 * 163 + off) @(negedge clk);
    check("abort_pre_txd",  32'(if_a.TXD), 32'd0);
    check("abort_pre_leds", 32'(if_a.LEDS), 32'(5'b00100));
    #2;
    rst = 1'b1;
    #1;
    check("abort_txd",  32'(if_a.TXD), 32'd1);
    check("abort_leds", 32'(if_a.LEDS), 32'd0);
    $display("[TB] reset asserted %0d cycles into frame 2", off);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    run_program(0, 16, ROM_DEF, 2, "restart");

    check("rxd_indep", 32'(rxd_diff), 32'd0);

    rst_c = 1'b0;
    run_program(1, 4, ROM_OVR, 34, "ovr");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
